// File: rtl/game_progress_ctrl_if.sv
// game_progress_ctrl_if
//   Bundles the game-progress controller's control and status signals.
//   master : the game environment. Drives start/pause and the collision
//            vector. Receives the HUD/spawner outputs and the hit_clr pulse.
//   slave  : the controller itself (game_progress_ctrl).
// Signals
//   start, pause  level requests, sampled each game tick
//   hit_vec       sticky per-object collision flags (N_OBJ wide)
//   hit_clr       one-tick pulse asking upstream to clear hit_vec
//   state         0 IDLE, 1 RUN, 2 GRACE, 3 PAUSE, 4 OVER
//   status        1 while not game over
//   game_over     1 while in OVER
//   score         current score (SCORE_W wide)
//   high_score    best final score since reset (SCORE_W wide)
//   num_squares   requested obstacle count (OBJ_W wide)
//   lives         remaining lives
interface game_progress_ctrl_if #(
  parameter int N_OBJ   = 16,
  parameter int SCORE_W = 16,
  parameter int OBJ_W   = 6
);
  logic               start;
  logic               pause;
  logic [N_OBJ-1:0]   hit_vec;
  logic               hit_clr;
  logic [2:0]         state;
  logic               status;
  logic               game_over;
  logic [SCORE_W-1:0] score;
  logic [SCORE_W-1:0] high_score;
  logic [OBJ_W-1:0]   num_squares;
  logic [3:0]         lives;

  modport master (
    output start, pause, hit_vec,
    input  hit_clr, state, status, game_over, score, high_score, num_squares, lives
  );

  modport slave (
    input  start, pause, hit_vec,
    output hit_clr, state, status, game_over, score, high_score, num_squares, lives
  );
endinterface

// File: rtl/game_progress_ctrl.sv
// game_progress_ctrl
//   Owns score, difficulty (num_squares), lives and high score for the game.
//   Advances once per 1 Hz game tick through IDLE/RUN/GRACE/PAUSE/OVER.
//   Consumes the collision vector and acknowledges it with a one-tick hit_clr.
//   All outputs are registered.
// Ports
//   clk_1Hz  game tick clock, rising edge
//   reset    asynchronous, active-high
//   bus      game_progress_ctrl_if.slave. Provides start/pause/hit_vec in.
//            Drives hit_clr, state, status, game_over, score, high_score,
//            num_squares and lives out.
module game_progress_ctrl #(
  parameter int N_OBJ      = 16,
  parameter int SCORE_W    = 16,
  parameter int OBJ_W      = 6,
  parameter int LEVEL_STEP = 5,
  parameter int MAX_OBJ    = 16,
  parameter int LIVES      = 3,
  parameter int GRACE      = 2
) (
  input logic                 clk_1Hz,
  input logic                 reset,
  game_progress_ctrl_if.slave bus
);

  localparam int LW = (LEVEL_STEP > 1) ? $clog2(LEVEL_STEP) : 1;
  localparam int GW = (GRACE > 1) ? $clog2(GRACE + 1) : 1;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RUN   = 3'd1,
    GRACE_ST = 3'd2,
    PAUSE = 3'd3,
    OVER  = 3'd4
  } state_t;

  state_t             state_r;
  state_t             ret_r;
  logic [SCORE_W-1:0] score_r;
  logic [SCORE_W-1:0] high_r;
  logic [OBJ_W-1:0]   nsq_r;
  logic [3:0]         lives_r;
  logic [LW-1:0]      lvl_cnt_r;
  logic [GW-1:0]      grace_cnt_r;
  logic               hit_clr_r;
  logic               status_r;
  logic               game_over_r;

  logic               hit_any_s;
  logic [SCORE_W-1:0] score_inc_s;
  logic [OBJ_W-1:0]   nsq_inc_s;
  logic [LW-1:0]      lvl_next_s;
  logic [SCORE_W-1:0] high_next_s;

  // Larger of two scores; used to fold the final score into high_score.
  function automatic logic [SCORE_W-1:0] max_score(input logic [SCORE_W-1:0] a,
                                                   input logic [SCORE_W-1:0] b);
    return (a > b) ? a : b;
  endfunction

  // Saturating increment of the score.
  function automatic logic [SCORE_W-1:0] sat_inc_score(input logic [SCORE_W-1:0] s);
    return (s == {SCORE_W{1'b1}}) ? s : s + SCORE_W'(1);
  endfunction

  // Saturating increment of the obstacle count, capped at MAX_OBJ.
  function automatic logic [OBJ_W-1:0] sat_inc_obj(input logic [OBJ_W-1:0] n);
    return (n >= OBJ_W'(MAX_OBJ)) ? n : n + OBJ_W'(1);
  endfunction

  // Next values of the score-tick counters, shared by RUN and GRACE.
  always_comb begin
    hit_any_s   = |bus.hit_vec;
    score_inc_s = sat_inc_score(score_r);
    high_next_s = max_score(high_r, score_r);
    if (lvl_cnt_r == LW'(LEVEL_STEP - 1)) begin
      // Level boundary: wrap the sub-counter and request one more obstacle.
      lvl_next_s = '0;
      nsq_inc_s  = sat_inc_obj(nsq_r);
    end else begin
      lvl_next_s = lvl_cnt_r + LW'(1);
      nsq_inc_s  = nsq_r;
    end
  end

  // Game FSM with all counters and registered outputs.
  always_ff @(posedge clk_1Hz or posedge reset) begin
    if (reset) begin
      state_r     <= IDLE;
      ret_r       <= RUN;
      score_r     <= '0;
      high_r      <= '0;
      nsq_r       <= '0;
      lives_r     <= 4'(LIVES);
      lvl_cnt_r   <= '0;
      grace_cnt_r <= '0;
      hit_clr_r   <= 1'b0;
      status_r    <= 1'b1;
      game_over_r <= 1'b0;
    end else begin
      hit_clr_r <= 1'b0;
      case (state_r)
        IDLE, OVER: begin
          if (bus.start) begin
            // New game: high_score survives, everything else re-initialises.
            state_r     <= RUN;
            score_r     <= '0;
            nsq_r       <= '0;
            lives_r     <= 4'(LIVES);
            lvl_cnt_r   <= '0;
            status_r    <= 1'b1;
            game_over_r <= 1'b0;
          end
        end
        RUN: begin
          if (bus.pause) begin
            state_r <= PAUSE;
            ret_r   <= RUN;
          end else if (hit_any_s) begin
            hit_clr_r <= 1'b1;
            lives_r   <= lives_r - 4'd1;
            if (lives_r == 4'd1) begin
              // Fatal hit: the score of this tick is not awarded.
              state_r     <= OVER;
              status_r    <= 1'b0;
              game_over_r <= 1'b1;
              high_r      <= high_next_s;
            end else if (GRACE == 0) begin
              state_r <= RUN;
            end else begin
              state_r     <= GRACE_ST;
              grace_cnt_r <= GW'(GRACE);
            end
          end else begin
            score_r   <= score_inc_s;
            nsq_r     <= nsq_inc_s;
            lvl_cnt_r <= lvl_next_s;
          end
        end
        GRACE_ST: begin
          if (bus.pause) begin
            state_r <= PAUSE;
            ret_r   <= GRACE_ST;
          end else begin
            // Invulnerable: hits are only acknowledged, never charged.
            hit_clr_r   <= hit_any_s;
            score_r     <= score_inc_s;
            nsq_r       <= nsq_inc_s;
            lvl_cnt_r   <= lvl_next_s;
            grace_cnt_r <= grace_cnt_r - GW'(1);
            if (grace_cnt_r == GW'(1)) begin
              state_r <= RUN;
            end
          end
        end
        PAUSE: begin
          if (!bus.pause) begin
            state_r <= ret_r;
          end
        end
        default: begin
          state_r     <= IDLE;
          status_r    <= 1'b1;
          game_over_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.state       = state_r;
  assign bus.status      = status_r;
  assign bus.game_over   = game_over_r;
  assign bus.score       = score_r;
  assign bus.high_score  = high_r;
  assign bus.num_squares = nsq_r;
  assign bus.lives       = lives_r;
  assign bus.hit_clr     = hit_clr_r;

endmodule
